qnet_rx_deframer: RTL and testbench
===================================

// Module: qnet_rx_deframer
// PURPOSE
//  Receive-side deframer for the QNET simplex link, channel A. Takes 64-bit Aurora RX
//  AXI-stream beats (no backpressure), assembles 2-beat packets (header, data), checks
//  framing and destination, timestamps arrival, buffers up to 2 commands, and presents
//  them to the command decoder through a req/ack handshake. Counterpart of the channel-B
//  framer that drives axi_tx_* from tx_req/tx_header/tx_data.
// PARAMETERS
//  BCAST_ID  10'h3FF  destination ID accepted by every node
//  FWD_EN    1        1: packets for other nodes raise fwd_req_o; 0: silently dropped
// PORTS
//  t_clk_i          in   1    time/link clock
//  t_rst_ni         in   1    async active-low reset
//  id_i             in   10   this node's ID (param.ID)
//  t_time_abs       in   48   absolute time; [31:0] captured at header beat
//  rx_tvalid_i      in   1    channel A RX beat valid
//  rx_tdata_i       in   64   channel A RX beat data
//  rx_tlast_i       in   1    channel A RX last beat
//  cmd_req_o        out  1    buffered command available (level)
//  cmd_ack_i        in   1    decoder consumed head command (1-cycle pulse)
//  cmd_header_o     out  64   head command header
//  cmd_data_o       out  2x32 head command data {[0]=beat1[63:32],[1]=beat1[31:0]}
//  cmd_time_o       out  32   head command arrival time
//  fwd_req_o        out  1    1-cycle pulse: non-local packet seen; fwd_* valid same cycle
//  fwd_header_o     out  64   header of forwarded packet
//  fwd_data_o       out  64   data beat of forwarded packet
//  err_o            out  3    sticky {ovf, long, runt}; cleared by err_clr_i
//  err_clr_i        in   1    clear err_o
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, buffer empty. Reset mid-packet discards partial packet.
//  Header fields (qnet_pkg): [63:59] op, [58:55] flags, [54:45] dst, [44:35] src, [34:0] rsvd.
//  FSM, advances only on rx_tvalid_i:
//   IDLE: beat & !tlast -> latch header + t_time_abs[31:0], go DATA.
//         beat & tlast  -> runt error (err_o[0]), stay IDLE.
//   DATA: beat & tlast  -> packet complete, go IDLE.
//         beat & !tlast -> long error (err_o[1]), go DROP, no packet.
//   DROP: discard beats; tlast -> IDLE.
//  Completion (registered, 1 cycle after last beat):
//   dst==id_i or dst==BCAST_ID -> push to buffer; broadcast additionally forwarded if FWD_EN.
//   else FWD_EN ? pulse fwd_req_o : drop.
//  Buffer: 2-entry FIFO, head on cmd_* outputs; cmd_req_o = !empty.
//   Push into empty: cmd_req_o high 1 cycle after completion (2 after last beat total).
//   cmd_ack_i pops head; next entry visible the following cycle. ack while empty ignored.
//   Push and pop same cycle: both happen, occupancy unchanged.
//   Push when full and no pop: new packet dropped, err_o[2] set; head unchanged.
//  err_o: bits set on event, held until err_clr_i; set wins over simultaneous clear.
//  Back-to-back packets with no idle cycles sustained at full rate (1 packet / 2 beats).
// CONFIGURATION
//  QNET_RX_STATS_EN defined: adds outputs pkt_cnt_o[15:0] (accepted local packets),
//   fwd_cnt_o[15:0] (forwarded), err_cnt_o[7:0] (any error event); counters saturate,
//   reset to 0, cleared by err_clr_i. Undefined: ports absent, no counter logic.
// STRUCTURE
//  qnet_pkg: TYPE_QNET_HDR struct (op/flags/dst/src/rsvd), field positions, BCAST default,
//   TYPE_RX_ST enum {IDLE, DATA, DROP}, TYPE_RX_CMD struct {header, data[2], time}.
//  Sub-module qnet_rx_fifo2: 2-entry TYPE_RX_CMD FIFO, push/pop/full/empty, same-cycle
//   push+pop. FSM, destination filter, error latch, stats stay in top.
// TESTING
//  1 id=5, header dst=5 op=3, data 64'hAAAA_BBBB_CCCC_DDDD at time 100 -> cmd_req_o high
//    2 cycles after last beat, cmd_data_o={32'hAAAABBBB,32'hCCCCDDDD}, cmd_time_o=100.
//  2 three local packets back-to-back, no ack -> first two buffered, third dropped,
//    err_o=3'b100; ack twice -> heads 1 then 2 in order, cmd_req_o falls after second.
//  3 single beat with tlast -> err_o[0]=1, no cmd; 3-beat packet -> err_o[1]=1, no cmd,
//    following valid packet accepted normally.
//  4 dst=7, id=5, FWD_EN=1 -> fwd_req_o 1-cycle pulse with header/data, cmd_req_o stays 0;
//    dst=3FF -> both buffered and forwarded.
//  5 assert t_rst_ni low after header beat, release, send data beat with tlast -> runt error,
//    no cmd; all outputs 0 during reset.
//  6 QNET_RX_STATS_EN: sequence of 4 local, 2 forwarded, 1 runt -> pkt_cnt_o=4,
//    fwd_cnt_o=2, err_cnt_o=1; err_clr_i -> all 0.

Source files
------------

// File: rtl/qnet_pkg.sv
// Shared QNET types: header layout, RX deframer state and buffered command record.
package qnet_pkg;

  localparam logic [9:0] BCAST_ID_DEF = 10'h3FF;

  localparam int unsigned HDR_OP_LSB    = 59;
  localparam int unsigned HDR_FLAGS_LSB = 55;
  localparam int unsigned HDR_DST_MSB   = 54;
  localparam int unsigned HDR_DST_LSB   = 45;
  localparam int unsigned HDR_SRC_LSB   = 35;

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  flags;
    logic [9:0]  dst;
    logic [9:0]  src;
    logic [34:0] rsvd;
  } TYPE_QNET_HDR;

  typedef enum logic [1:0] {IDLE, DATA, DROP} TYPE_RX_ST;

  // data[0] is the upper word of the data beat, so {data} equals the beat itself.
  typedef struct packed {
    logic [63:0]       header;
    logic [0:1][31:0]  data;
    logic [31:0]       tstamp;
  } TYPE_RX_CMD;

  localparam int unsigned RX_CMD_W = $bits(TYPE_RX_CMD);

endpackage

// File: rtl/qnet_rx_fifo2.sv
// Two-entry command FIFO; head is presented combinationally from storage registers.
module qnet_rx_fifo2
  import qnet_pkg::*;
(
  input  logic                t_clk_i,
  input  logic                t_rst_ni,
  input  logic                push_i,
  input  logic [RX_CMD_W-1:0] wdata_i,
  input  logic                pop_i,
  output logic [RX_CMD_W-1:0] rdata_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [RX_CMD_W-1:0] mem_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          cnt_q;
  logic                do_push;
  logic                do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the same cycle, so push into a full FIFO succeeds then.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/qnet_rx_deframer.sv
// QNET channel-A RX deframer: 2-beat packet assembly, destination filter, 2-deep command buffer.
// Optional QNET_RX_STATS_EN adds saturating packet/forward/error counters.
module qnet_rx_deframer
  import qnet_pkg::*;
#(
  parameter logic [9:0] BCAST_ID = BCAST_ID_DEF,
  parameter bit         FWD_EN   = 1'b1
) (
  input  logic        t_clk_i,
  input  logic        t_rst_ni,
  input  logic [9:0]  id_i,
  input  logic [47:0] t_time_abs,
  input  logic        rx_tvalid_i,
  input  logic [63:0] rx_tdata_i,
  input  logic        rx_tlast_i,
  output logic        cmd_req_o,
  input  logic        cmd_ack_i,
  output logic [63:0] cmd_header_o,
  output logic [63:0] cmd_data_o,
  output logic [31:0] cmd_time_o,
  output logic        fwd_req_o,
  output logic [63:0] fwd_header_o,
  output logic [63:0] fwd_data_o,
  output logic [2:0]  err_o,
  input  logic        err_clr_i
`ifdef QNET_RX_STATS_EN
  ,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] fwd_cnt_o,
  output logic [7:0]  err_cnt_o
`endif
);

  TYPE_RX_ST   state_q;
  logic [63:0] hdr_q;
  logic [63:0] data_q;
  logic [31:0] time_q;
  logic        push_q;
  logic        fwd_req_q;
  logic [2:0]  err_q;
  logic [2:0]  err_set;
  logic [9:0]  dst;
  logic        is_own;
  logic        is_bcast;
  logic        fwd_hit;
  logic        fifo_full;
  logic        fifo_empty;
  logic        unused_time;
  TYPE_RX_CMD  push_cmd;
  TYPE_RX_CMD  head_cmd;

  assign unused_time = ^t_time_abs[47:32];
  assign dst      = hdr_q[HDR_DST_MSB:HDR_DST_LSB];
  assign is_own   = (dst == id_i);
  assign is_bcast = (dst == BCAST_ID);
  assign fwd_hit  = FWD_EN && (is_bcast || !is_own);

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      data_q    <= '0;
      time_q    <= '0;
      push_q    <= 1'b0;
      fwd_req_q <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      fwd_req_q <= 1'b0;
      if (rx_tvalid_i) begin
        unique case (state_q)
          IDLE: begin
            if (!rx_tlast_i) begin
              hdr_q   <= rx_tdata_i;
              time_q  <= t_time_abs[31:0];
              state_q <= DATA;
            end
          end
          DATA: begin
            if (rx_tlast_i) begin
              data_q    <= rx_tdata_i;
              push_q    <= is_own || is_bcast;
              fwd_req_q <= fwd_hit;
              state_q   <= IDLE;
            end else begin
              state_q <= DROP;
            end
          end
          DROP: if (rx_tlast_i) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // hdr_q/data_q still hold the completed packet in the cycle push_q/fwd_req_q are high.
  assign push_cmd.header = hdr_q;
  assign push_cmd.data   = data_q;
  assign push_cmd.tstamp = time_q;

  qnet_rx_fifo2 u_fifo (
    .t_clk_i  (t_clk_i),
    .t_rst_ni (t_rst_ni),
    .push_i   (push_q),
    .wdata_i  (push_cmd),
    .pop_i    (cmd_ack_i),
    .rdata_o  (head_cmd),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign cmd_req_o    = !fifo_empty;
  assign cmd_header_o = head_cmd.header;
  assign cmd_data_o   = head_cmd.data;
  assign cmd_time_o   = head_cmd.tstamp;
  assign fwd_req_o    = fwd_req_q;
  assign fwd_header_o = hdr_q;
  assign fwd_data_o   = data_q;

  assign err_set[0] = rx_tvalid_i && (state_q == IDLE) && rx_tlast_i;
  assign err_set[1] = rx_tvalid_i && (state_q == DATA) && !rx_tlast_i;
  assign err_set[2] = push_q && fifo_full && !cmd_ack_i;

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      err_q <= 3'b000;
    end else begin
      err_q <= (err_clr_i ? 3'b000 : err_q) | err_set;
    end
  end

  assign err_o = err_q;

`ifdef QNET_RX_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] fwd_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        pkt_ok;

  assign pkt_ok = push_q && (!fifo_full || cmd_ack_i);

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      pkt_cnt_q <= '0;
      fwd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      pkt_cnt_q <= '0;
      fwd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_ok && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (fwd_req_q && (fwd_cnt_q != 16'hFFFF)) fwd_cnt_q <= fwd_cnt_q + 16'd1;
      if ((|err_set) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign fwd_cnt_o = fwd_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_qnet_rx_deframer.sv
// Scoreboard bench for qnet_rx_deframer: expected commands/forwards queued at send time,
// compared by a negedge monitor on ack/fwd_req.
module tb_qnet_rx_deframer;

  logic        t_clk_i;
  logic        t_rst_ni;
  logic [9:0]  id_i;
  logic [47:0] t_time_abs;
  logic        rx_tvalid_i;
  logic [63:0] rx_tdata_i;
  logic        rx_tlast_i;
  logic        cmd_req_o;
  logic        cmd_ack_i;
  logic [63:0] cmd_header_o;
  logic [63:0] cmd_data_o;
  logic [31:0] cmd_time_o;
  logic        fwd_req_o;
  logic [63:0] fwd_header_o;
  logic [63:0] fwd_data_o;
  logic [2:0]  err_o;
  logic        err_clr_i;
`ifdef QNET_RX_STATS_EN
  logic [15:0] pkt_cnt_o;
  logic [15:0] fwd_cnt_o;
  logic [7:0]  err_cnt_o;
`endif

  qnet_rx_deframer dut (
    .t_clk_i      (t_clk_i),
    .t_rst_ni     (t_rst_ni),
    .id_i         (id_i),
    .t_time_abs   (t_time_abs),
    .rx_tvalid_i  (rx_tvalid_i),
    .rx_tdata_i   (rx_tdata_i),
    .rx_tlast_i   (rx_tlast_i),
    .cmd_req_o    (cmd_req_o),
    .cmd_ack_i    (cmd_ack_i),
    .cmd_header_o (cmd_header_o),
    .cmd_data_o   (cmd_data_o),
    .cmd_time_o   (cmd_time_o),
    .fwd_req_o    (fwd_req_o),
    .fwd_header_o (fwd_header_o),
    .fwd_data_o   (fwd_data_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i)
`ifdef QNET_RX_STATS_EN
    ,
    .pkt_cnt_o    (pkt_cnt_o),
    .fwd_cnt_o    (fwd_cnt_o),
    .err_cnt_o    (err_cnt_o)
`endif
  );

  typedef struct {
    logic [63:0] hdr;
    logic [63:0] data;
    logic [31:0] tm;
  } exp_t;

  exp_t cmd_q[$];
  exp_t fwd_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial t_clk_i = 1'b0;
  always #5 t_clk_i = ~t_clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: head is compared when the decoder acks it; forwards when fwd_req_o pulses.
  always @(negedge t_clk_i) begin
    if (t_rst_ni) begin
      if (cmd_req_o && cmd_ack_i) begin
        if (cmd_q.size() == 0) begin
          chk("cmd_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = cmd_q.pop_front();
          chk("cmd_header", cmd_header_o, e.hdr);
          chk("cmd_data", cmd_data_o, e.data);
          chk("cmd_time", {32'd0, cmd_time_o}, {32'd0, e.tm});
        end
      end
      if (fwd_req_o) begin
        if (fwd_q.size() == 0) begin
          chk("fwd_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = fwd_q.pop_front();
          chk("fwd_header", fwd_header_o, e.hdr);
          chk("fwd_data", fwd_data_o, e.data);
        end
      end
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [9:0] dst);
    return {op, 4'h0, dst, 10'h001, 35'h0};
  endfunction

  task automatic tick();
    @(posedge t_clk_i);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic l);
    rx_tvalid_i = 1'b1;
    rx_tdata_i  = d;
    rx_tlast_i  = l;
    tick();
  endtask

  task automatic idle(input int n);
    rx_tvalid_i = 1'b0;
    rx_tlast_i  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_pkt(input logic [63:0] h, input logic [63:0] d, input logic [31:0] tm,
                          input bit exp_cmd, input bit exp_fwd);
    exp_t e;
    e.hdr  = h;
    e.data = d;
    e.tm   = tm;
    if (exp_cmd) cmd_q.push_back(e);
    if (exp_fwd) fwd_q.push_back(e);
    t_time_abs = {16'hBEEF, tm};
    beat(h, 1'b0);
    beat(d, 1'b1);
    rx_tvalid_i = 1'b0;
    rx_tlast_i  = 1'b0;
  endtask

  task automatic ack();
    cmd_ack_i = 1'b1;
    tick();
    cmd_ack_i = 1'b0;
  endtask

  task automatic clr();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_req"}, {63'd0, cmd_req_o}, 64'd0);
    chk({tag, "_fwd_req"}, {63'd0, fwd_req_o}, 64'd0);
    chk({tag, "_err"}, {61'd0, err_o}, 64'd0);
    chk({tag, "_cmd_header"}, cmd_header_o, 64'd0);
    chk({tag, "_cmd_data"}, cmd_data_o, 64'd0);
    chk({tag, "_cmd_time"}, {32'd0, cmd_time_o}, 64'd0);
    chk({tag, "_fwd_header"}, fwd_header_o, 64'd0);
    chk({tag, "_fwd_data"}, fwd_data_o, 64'd0);
  endtask

  initial begin
    t_rst_ni    = 1'b0;
    id_i        = 10'd5;
    t_time_abs  = '0;
    rx_tvalid_i = 1'b0;
    rx_tdata_i  = '0;
    rx_tlast_i  = 1'b0;
    cmd_ack_i   = 1'b0;
    err_clr_i   = 1'b0;
    repeat (2) @(negedge t_clk_i);
    chk_all_zero("rst");
    tick();
    t_rst_ni = 1'b1;
    tick();

    // 1: single local packet, req latency and payload mapping
    send_pkt(mk_hdr(5'd3, 10'd5), 64'hAAAA_BBBB_CCCC_DDDD, 32'd100, 1'b1, 1'b0);
    @(negedge t_clk_i);
    chk("t1_req_after1", {63'd0, cmd_req_o}, 64'd0);
    @(negedge t_clk_i);
    chk("t1_req_after2", {63'd0, cmd_req_o}, 64'd1);
    chk("t1_data", cmd_data_o, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("t1_time", {32'd0, cmd_time_o}, 64'd100);
    chk("t1_fwd", {63'd0, fwd_req_o}, 64'd0);
    tick();
    ack();
    @(negedge t_clk_i);
    chk("t1_req_popped", {63'd0, cmd_req_o}, 64'd0);
    tick();
    ack(); // ack while empty is ignored
    @(negedge t_clk_i);
    chk("t1_ack_empty", {63'd0, cmd_req_o}, 64'd0);
    tick();

    // 2: three back-to-back local packets, third overflows
    send_pkt(mk_hdr(5'd1, 10'd5), 64'h1111_0000_1111_0001, 32'd200, 1'b1, 1'b0);
    send_pkt(mk_hdr(5'd2, 10'd5), 64'h2222_0000_2222_0002, 32'd202, 1'b1, 1'b0);
    send_pkt(mk_hdr(5'd4, 10'd5), 64'h3333_0000_3333_0003, 32'd204, 1'b0, 1'b0);
    idle(4);
    @(negedge t_clk_i);
    chk("t2_err_ovf", {61'd0, err_o}, 64'd4);
    chk("t2_req", {63'd0, cmd_req_o}, 64'd1);
    chk("t2_head1", cmd_header_o, mk_hdr(5'd1, 10'd5));
    tick();
    ack();
    ack();
    @(negedge t_clk_i);
    chk("t2_req_drained", {63'd0, cmd_req_o}, 64'd0);
    tick();
    clr();
    @(negedge t_clk_i);
    chk("t2_err_clr", {61'd0, err_o}, 64'd0);
    tick();

    // 3: runt, then long packet, then normal packet
    beat(64'hDEAD_0000_0000_0001, 1'b1);
    idle(2);
    @(negedge t_clk_i);
    chk("t3_runt", {61'd0, err_o}, 64'd1);
    chk("t3_runt_nocmd", {63'd0, cmd_req_o}, 64'd0);
    tick();
    clr();
    beat(mk_hdr(5'd6, 10'd5), 1'b0);
    beat(64'h5555_5555_5555_5555, 1'b0);
    beat(64'h6666_6666_6666_6666, 1'b1);
    idle(3);
    @(negedge t_clk_i);
    chk("t3_long", {61'd0, err_o}, 64'd2);
    chk("t3_long_nocmd", {63'd0, cmd_req_o}, 64'd0);
    tick();
    clr();
    send_pkt(mk_hdr(5'd7, 10'd5), 64'h7777_8888_9999_AAAA, 32'd300, 1'b1, 1'b0);
    idle(2);
    @(negedge t_clk_i);
    chk("t3_after_req", {63'd0, cmd_req_o}, 64'd1);
    tick();
    ack();
    idle(1);

    // 4: non-local forward, then broadcast (buffered and forwarded)
    send_pkt(mk_hdr(5'd8, 10'd7), 64'h0123_4567_89AB_CDEF, 32'd400, 1'b0, 1'b1);
    @(negedge t_clk_i);
    chk("t4_fwd_pulse", {63'd0, fwd_req_o}, 64'd1);
    @(negedge t_clk_i);
    chk("t4_fwd_end", {63'd0, fwd_req_o}, 64'd0);
    chk("t4_nocmd", {63'd0, cmd_req_o}, 64'd0);
    tick();
    send_pkt(mk_hdr(5'd9, 10'h3FF), 64'hFEDC_BA98_7654_3210, 32'd500, 1'b1, 1'b1);
    idle(3);
    @(negedge t_clk_i);
    chk("t4_bcast_req", {63'd0, cmd_req_o}, 64'd1);
    tick();
    ack();
    idle(1);

    // 5: reset mid-packet discards buffered state and partial packet
    send_pkt(mk_hdr(5'd10, 10'd5), 64'h0BAD_0BAD_0BAD_0BAD, 32'd600, 1'b0, 1'b0);
    idle(3);
    @(negedge t_clk_i);
    chk("t5_pre_req", {63'd0, cmd_req_o}, 64'd1);
    tick();
    beat(mk_hdr(5'd11, 10'd5), 1'b0);
    rx_tvalid_i = 1'b0;
    t_rst_ni    = 1'b0;
    @(negedge t_clk_i);
    chk_all_zero("t5_rst");
    tick();
    t_rst_ni = 1'b1;
    tick();
    beat(64'h1234_1234_1234_1234, 1'b1);
    idle(3);
    @(negedge t_clk_i);
    chk("t5_runt", {61'd0, err_o}, 64'd1);
    chk("t5_nocmd", {63'd0, cmd_req_o}, 64'd0);
    tick();
    clr();

`ifdef QNET_RX_STATS_EN
    // 6: statistics counters
    for (int i = 0; i < 4; i++) begin
      send_pkt(mk_hdr(5'd12, 10'd5), {32'hC0DE_0000, i}, 32'd700 + i, 1'b1, 1'b0);
      idle(2);
      ack();
    end
    for (int i = 0; i < 2; i++) begin
      send_pkt(mk_hdr(5'd13, 10'd9), {32'hF0F0_0000, i}, 32'd800 + i, 1'b0, 1'b1);
      idle(2);
    end
    beat(64'h0, 1'b1);
    idle(2);
    @(negedge t_clk_i);
    chk("t6_pkt_cnt", {48'd0, pkt_cnt_o}, 64'd4);
    chk("t6_fwd_cnt", {48'd0, fwd_cnt_o}, 64'd2);
    chk("t6_err_cnt", {56'd0, err_cnt_o}, 64'd1);
    tick();
    clr();
    @(negedge t_clk_i);
    chk("t6_clr_pkt", {48'd0, pkt_cnt_o}, 64'd0);
    chk("t6_clr_fwd", {48'd0, fwd_cnt_o}, 64'd0);
    chk("t6_clr_err", {56'd0, err_cnt_o}, 64'd0);
    tick();
`endif

    idle(2);
    chk("sb_cmd_left", 64'(cmd_q.size()), 64'd0);
    chk("sb_fwd_left", 64'(fwd_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
